// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg -- default 800x600@60 timing, counter/colour types, bar helper
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vga_pkg;

   localparam int VGA_CNT_W     = 11;
   localparam int RGB_W         = 12;
   localparam int VGA_MAX_TOTAL = 2048;

   localparam int VGA_H_ACTIVE  = 800;
   localparam int VGA_H_FP      = 40;
   localparam int VGA_H_SYNC    = 128;
   localparam int VGA_H_BP      = 88;
   localparam int VGA_H_TOTAL   = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

   localparam int VGA_V_ACTIVE  = 600;
   localparam int VGA_V_FP      = 1;
   localparam int VGA_V_SYNC    = 4;
   localparam int VGA_V_BP      = 23;
   localparam int VGA_V_TOTAL   = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   typedef logic [VGA_CNT_W-1:0] cnt_t;
   typedef logic [RGB_W-1:0]     rgb_t;

   // Eight 128-pixel vertical bars; each colour channel is one bit of the bar index.
   function automatic rgb_t bar_colour(input cnt_t hcount, input logic blank);
      logic [2:0] idx;
      idx = hcount[9:7];
      if (blank) begin
         return '0;
      end
      return {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
   endfunction

endpackage

`default_nettype wire

// File: rtl/vga_if.sv
// ----------------------------------------------------------------------------
// vga_if -- pixel counters, sync/blank flags and colour for the video pipeline
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface vga_if;
   import vga_pkg::*;

   cnt_t hcount;
   cnt_t vcount;
   logic hsync;
   logic vsync;
   logic hblnk;
   logic vblnk;
   rgb_t rgb;

   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ----------------------------------------------------------------------------
// vga_axis_counter -- one timing axis: wrapping counter with registered blank/sync
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE = VGA_H_ACTIVE,
   parameter int FP     = VGA_H_FP,
   parameter int SYNC   = VGA_H_SYNC,
   parameter int BP     = VGA_H_BP
) (
   input  logic clk,
   input  logic rst,
   input  logic cnt_en,
   output logic wrap,
   output cnt_t count,
   output logic blnk,
   output logic sync,
   output cnt_t count_nxt,
   output logic blnk_nxt
);

   localparam int TOTAL = ACTIVE + FP + SYNC + BP;

   if (TOTAL > VGA_MAX_TOTAL) begin : g_total_check
      $error("vga_axis_counter: total of %0d exceeds %0d", TOTAL, VGA_MAX_TOTAL);
   end

   // One extra bit so a sync edge sitting exactly at 2048 does not alias to 0.
   localparam logic [VGA_CNT_W:0] LAST       = (VGA_CNT_W+1)'(TOTAL - 1);
   localparam logic [VGA_CNT_W:0] BLNK_START = (VGA_CNT_W+1)'(ACTIVE);
   localparam logic [VGA_CNT_W:0] SYNC_START = (VGA_CNT_W+1)'(ACTIVE + FP);
   localparam logic [VGA_CNT_W:0] SYNC_END   = (VGA_CNT_W+1)'(ACTIVE + FP + SYNC);

   logic at_last;
   logic sync_nxt;

   assign at_last = ({1'b0, count} == LAST);
   assign wrap    = cnt_en && at_last;

   always_comb begin
      count_nxt = count;
      if (cnt_en) begin
         count_nxt = at_last ? '0 : count + cnt_t'(1);
      end
   end

   // Flags come from the next count so they line up with the count they describe.
   assign blnk_nxt = ({1'b0, count_nxt} >= BLNK_START);
   assign sync_nxt = ({1'b0, count_nxt} >= SYNC_START) && ({1'b0, count_nxt} < SYNC_END);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         blnk  <= 1'b0;
         sync  <= 1'b0;
      end else begin
         count <= count_nxt;
         blnk  <= blnk_nxt;
         sync  <= sync_nxt;
      end
   end

endmodule

`default_nettype wire

// File: rtl/vga_timing.sv
// ----------------------------------------------------------------------------
// vga_timing -- free-running VGA timing generator; colour bars on rgb when
// VGA_TIMING_TEST_PATTERN_EN is defined, otherwise rgb is tied low. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vga_timing
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP
) (
   input  logic clk,
   input  logic rst,
   vga_if.out   vga_out
);

   cnt_t h_count;
   cnt_t h_count_nxt;
   logic h_wrap;
   logic h_blnk;
   logic h_blnk_nxt;
   logic h_sync;

   cnt_t v_count;
   cnt_t v_count_nxt;
   logic v_wrap;
   logic v_blnk;
   logic v_blnk_nxt;
   logic v_sync;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h_axis (
      .clk       (clk),
      .rst       (rst),
      .cnt_en    (1'b1),
      .wrap      (h_wrap),
      .count     (h_count),
      .blnk      (h_blnk),
      .sync      (h_sync),
      .count_nxt (h_count_nxt),
      .blnk_nxt  (h_blnk_nxt)
   );

   // The vertical axis advances only on the edge where the line wraps.
   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v_axis (
      .clk       (clk),
      .rst       (rst),
      .cnt_en    (h_wrap),
      .wrap      (v_wrap),
      .count     (v_count),
      .blnk      (v_blnk),
      .sync      (v_sync),
      .count_nxt (v_count_nxt),
      .blnk_nxt  (v_blnk_nxt)
   );

`ifdef VGA_TIMING_TEST_PATTERN_EN
   rgb_t rgb_q;
   logic unused_axis;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rgb_q <= '0;
      end else begin
         rgb_q <= bar_colour(h_count_nxt, h_blnk_nxt | v_blnk_nxt);
      end
   end

   assign unused_axis = ^{v_count_nxt, v_wrap};
   assign vga_out.rgb = rgb_q;
`else
   logic unused_axis;

   assign unused_axis = ^{h_count_nxt, h_blnk_nxt, v_count_nxt, v_blnk_nxt, v_wrap};
   assign vga_out.rgb = '0;
`endif

   assign vga_out.hcount = h_count;
   assign vga_out.vcount = v_count;
   assign vga_out.hsync  = h_sync;
   assign vga_out.vsync  = v_sync;
   assign vga_out.hblnk  = h_blnk;
   assign vga_out.vblnk  = v_blnk;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing.sv
// ----------------------------------------------------------------------------
// tb_vga_timing -- default-size generator against a hand-computed table, plus a
// tiny-geometry instance checked every cycle across whole frames. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vga_timing;
   import vga_pkg::*;

`ifdef VGA_TIMING_TEST_PATTERN_EN
   localparam bit TP = 1'b1;
`else
   localparam bit TP = 1'b0;
`endif

   // Small geometry: 25 clocks per line, 12 lines per frame, 300 clocks per frame.
   localparam int SH_A = 16, SH_F = 2, SH_S = 4, SH_B = 3, SH_T = 25;
   localparam int SV_A = 6,  SV_F = 1, SV_S = 2, SV_B = 3, SV_T = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vga_if big_if ();
   vga_if small_if ();

   vga_timing u_big (
      .clk     (clk),
      .rst     (rst),
      .vga_out (big_if)
   );

   vga_timing #(
      .H_ACTIVE (SH_A), .H_FP (SH_F), .H_SYNC (SH_S), .H_BP (SH_B),
      .V_ACTIVE (SV_A), .V_FP (SV_F), .V_SYNC (SV_S), .V_BP (SV_B)
   ) u_small (
      .clk     (clk),
      .rst     (rst),
      .vga_out (small_if)
   );

   typedef struct {
      int          ph;
      int          n;
      logic [10:0] hc;
      logic [10:0] vc;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic [11:0] rgb;
   } vec_t;

   vec_t tab [24];
   int   nvec   = 0;
   int   vectors = 0;
   int   errors  = 0;

   function automatic logic [37:0] pk(input logic [10:0] hc, input logic [10:0] vc,
                                      input logic hs, input logic vs,
                                      input logic hb, input logic vb,
                                      input logic [11:0] rgb);
      return {hc, vc, hs, vs, hb, vb, rgb};
   endfunction

   function automatic logic [37:0] act_big();
      return pk(big_if.hcount, big_if.vcount, big_if.hsync, big_if.vsync,
                big_if.hblnk, big_if.vblnk, big_if.rgb);
   endfunction

   function automatic logic [37:0] act_small();
      return pk(small_if.hcount, small_if.vcount, small_if.hsync, small_if.vsync,
                small_if.hblnk, small_if.vblnk, small_if.rgb);
   endfunction

   // Position from elapsed clocks by division, not by counting.
   function automatic logic [37:0] small_exp(input int n);
      int hc;
      int vc;
      hc = n % SH_T;
      vc = (n / SH_T) % SV_T;
      return pk(11'(hc), 11'(vc),
                (hc >= SH_A + SH_F) && (hc < SH_A + SH_F + SH_S),
                (vc >= SV_A + SV_F) && (vc < SV_A + SV_F + SV_S),
                hc >= SH_A, vc >= SV_A, 12'h000);
   endfunction

   task automatic add(input int ph, input int n, input int hc, input int vc,
                      input logic hs, input logic vs, input logic hb, input logic vb,
                      input logic [11:0] rgb);
      tab[nvec] = '{ph, n, 11'(hc), 11'(vc), hs, vs, hb, vb, rgb};
      nvec++;
   endtask

   task automatic cmp(input string name, input int n, input logic [37:0] got,
                      input logic [37:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s n=%0d got hc=%0d vc=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h | want hc=%0d vc=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h",
                  name, n, got[37:27], got[26:16], got[15], got[14], got[13], got[12], got[11:0],
                  exp[37:27], exp[26:16], exp[15], exp[14], exp[13], exp[12], exp[11:0]);
      end
   endtask

   task automatic cmp_int(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, got, exp);
      end
   endtask

   task automatic check_table(input int ph, input int n, inout int ti);
      while (ti < nvec && tab[ti].ph == ph && tab[ti].n == n) begin
         cmp($sformatf("big_tab%0d", ti), n, act_big(),
             pk(tab[ti].hc, tab[ti].vc, tab[ti].hs, tab[ti].vs,
                tab[ti].hb, tab[ti].vb, tab[ti].rgb));
         ti++;
      end
   endtask

   initial begin
      int ti;
      int hs_cnt;
      int vs_cnt;

      //   ph  n     hc    vc  hs vs hb vb rgb
      add(0, 1,    1,    0,  0, 0, 0, 0, 12'h000);
      add(0, 127,  127,  0,  0, 0, 0, 0, 12'h000);
      add(0, 128,  128,  0,  0, 0, 0, 0, TP ? 12'h00F : 12'h000);
      add(0, 640,  640,  0,  0, 0, 0, 0, TP ? 12'hF0F : 12'h000);
      add(0, 799,  799,  0,  0, 0, 0, 0, TP ? 12'hFF0 : 12'h000);
      add(0, 800,  800,  0,  0, 0, 1, 0, 12'h000);
      add(0, 839,  839,  0,  0, 0, 1, 0, 12'h000);
      add(0, 840,  840,  0,  1, 0, 1, 0, 12'h000);
      add(0, 967,  967,  0,  1, 0, 1, 0, 12'h000);
      add(0, 968,  968,  0,  0, 0, 1, 0, 12'h000);
      add(0, 1055, 1055, 0,  0, 0, 1, 0, 12'h000);
      add(0, 1056, 0,    1,  0, 0, 0, 0, 12'h000);
      add(0, 1556, 500,  1,  0, 0, 0, 0, TP ? 12'h0FF : 12'h000);
      add(1, 1,    1,    0,  0, 0, 0, 0, 12'h000);
      add(1, 2,    2,    0,  0, 0, 0, 0, 12'h000);
      add(1, 600,  600,  0,  0, 0, 0, 0, TP ? 12'hF00 : 12'h000);

      repeat (10) begin
         @(negedge clk);
         cmp("reset_big", 0, act_big(), '0);
         cmp("reset_small", 0, act_small(), '0);
      end
      rst = 1'b0;

      ti = 0;
      hs_cnt = 0;
      for (int n = 1; n <= 1556; n++) begin
         @(negedge clk);
         cmp("small_model", n, act_small(), small_exp(n));
         if (n <= 1056 && big_if.hsync) hs_cnt++;
         check_table(0, n, ti);
      end
      cmp_int("hsync_width", hs_cnt, 128);

      // Asynchronous reset mid-line: outputs must clear before the next edge.
      #2 rst = 1'b1;
      #1;
      cmp("async_rst_big", -1, act_big(), '0);
      cmp("async_rst_small", -1, act_small(), '0);
      @(negedge clk);
      cmp("held_rst_big", -1, act_big(), '0);
      @(negedge clk);
      rst = 1'b0;

      vs_cnt = 0;
      for (int n = 1; n <= 2 * SH_T * SV_T; n++) begin
         @(negedge clk);
         cmp("small_model_r", n, act_small(), small_exp(n));
         if (n <= SH_T * SV_T && small_if.vsync) vs_cnt++;
         check_table(1, n, ti);
      end
      cmp_int("vsync_width", vs_cnt, SV_S * SH_T);
      cmp_int("table_done", ti, nvec);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire
